dp_accum: RTL and testbench

- Parametrised, single-clock successor to the two-operand adder datapath.
- Accepts a start pulse, then accumulates a fixed-length burst of NUM_OPS operands, either by add or subtract.
- Reports the result with a one-cycle done pulse, a sticky overflow/borrow flag and a ready handshake.
- Sits between the control FSM and the result register bank.

---
 rtl/dp_accum.sv | 122 ++++++++++++
 tb/tb_dp_accum.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dp_accum.sv
// dp_accum: burst accumulator (add or subtract) with done pulse and sticky overflow/borrow.
// Optional clamp-on-overflow instead of wrap when DP_ACCUM_SATURATE_EN is defined.
module dp_accum #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             busy,
  output logic [WIDTH-1:0] d_out,
  output logic             ovf,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(NUM_OPS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [7:0]       cnt;
  logic             ovf_int, ovf_nxt;
  logic             mode_sub;
  logic [WIDTH:0]   step_res;
  logic             accept, last_accept;

  // Returns {carry, sum}; with saturation the sum clamps to all ones on carry.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef DP_ACCUM_SATURATE_EN
    if (s[WIDTH]) s = {1'b1, {WIDTH{1'b1}}};
`endif
    return s;
  endfunction

  // Returns {borrow, diff}; with saturation the diff clamps to zero on borrow.
  function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic             borrow;
    logic [WIDTH-1:0] d;
    borrow = (a < b);
    d      = a - b;
`ifdef DP_ACCUM_SATURATE_EN
    if (borrow) d = '0;
`endif
    return {borrow, d};
  endfunction

  assign accept      = (state == ACC) && d_valid;
  assign last_accept = accept && (cnt == LAST_CNT);

  always_comb begin
    step_res = mode_sub ? sub_step(acc, d_in) : add_step(acc, d_in);
    acc_nxt  = step_res[WIDTH-1:0];
    ovf_nxt  = ovf_int | step_res[WIDTH];
    // The first operand seeds the accumulator and cannot raise the flag.
    if (cnt == 8'd0) begin
      acc_nxt = d_in;
      ovf_nxt = ovf_int;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    d_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = start ? ACC : IDLE;
      ACC: begin
        d_ready   = 1'b1;
        busy      = 1'b1;
        state_nxt = last_accept ? DONE : ACC;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; result is captured on the edge that enters DONE.
  always_ff @(negedge clka or posedge restart) begin
    if (restart) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      mode_sub <= 1'b0;
      d_out    <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        mode_sub <= op_sub;
        cnt      <= '0;
        ovf_int  <= 1'b0;
      end
      if (accept) begin
        acc     <= acc_nxt;
        ovf_int <= ovf_nxt;
        cnt     <= cnt + 8'd1;
      end
      if (last_accept) begin
        d_out <= acc_nxt;
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dp_accum.sv
// Directed testbench for dp_accum (WIDTH=4, NUM_OPS=4); expectations follow DP_ACCUM_SATURATE_EN.
module tb_dp_accum;

  logic       clka = 1'b0;
  logic       restart, start, op_sub, d_valid;
  logic [3:0] d_in;
  logic       d_ready, busy, ovf, done;
  logic [3:0] d_out;

  int n_cmp = 0;
  int n_bad = 0;

  dp_accum #(.WIDTH(4), .NUM_OPS(4)) dut (
    .clka(clka), .restart(restart), .start(start), .op_sub(op_sub),
    .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready), .busy(busy),
    .d_out(d_out), .ovf(ovf), .done(done)
  );

  always #5 clka = ~clka;

  // DUT acts on negedge; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Runs one transaction. Edge 0 samples start; done_step is the edge index after which done is first seen.
  task automatic burst(input logic sub, input logic [3:0] o0, input logic [3:0] o1,
                       input logic [3:0] o2, input logic [3:0] o3,
                       input int g0, input int g1, input int g2, input logic stray,
                       output int done_step, output int done_cnt,
                       output logic [3:0] res, output logic rovf);
    logic [3:0] ops[4];
    int gaps[3];
    int k;
    ops = '{o0, o1, o2, o3};
    gaps = '{g0, g1, g2};
    done_step = -1; done_cnt = 0; res = 4'hx; rovf = 1'bx; k = 0;
    op_sub = sub; start = 1'b1; d_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      start = stray; d_valid = 1'b1; d_in = ops[i]; op_sub = ~sub;
      step(); k++;
      if (done) begin done_cnt++; if (done_step < 0) begin done_step = k; res = d_out; rovf = ovf; end end
      if (i < 3) begin
        for (int g = 0; g < gaps[i]; g++) begin
          start = stray; d_valid = 1'b0; d_in = 4'hF;
          step(); k++;
          if (done) begin done_cnt++; if (done_step < 0) begin done_step = k; res = d_out; rovf = ovf; end end
        end
      end
    end
    d_valid = 1'b0; d_in = 4'h0; start = stray;
    for (int j = 0; j < 3; j++) begin
      step(); k++;
      start = 1'b0;
      if (done) begin done_cnt++; if (done_step < 0) begin done_step = k; res = d_out; rovf = ovf; end end
    end
  endtask

  task automatic test_reset();
    restart = 1'b1; start = 1'b0; op_sub = 1'b0; d_valid = 1'b0; d_in = 4'h0;
    #3;
    n_cmp++; if (d_out !== 4'h0) begin n_bad++; $display("FAIL reset_d_out: got %h want 0", d_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    step();
    restart = 1'b0;
    step();
  endtask

  task automatic test_add();
    int ds, dc; logic [3:0] r; logic v;
    burst(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 0, 0, 0, 1'b0, ds, dc, r, v);
    n_cmp++; if (ds !== 4) begin n_bad++; $display("FAIL add_done_edge: got %0d want 4", ds); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL add_done_count: got %0d want 1", dc); end
    n_cmp++; if (r !== 4'hA) begin n_bad++; $display("FAIL add_d_out: got %h want a", r); end
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL add_ovf: got %b want 0", v); end
    n_cmp++; if (d_out !== 4'hA) begin n_bad++; $display("FAIL add_d_out_hold: got %h want a", d_out); end
  endtask

  task automatic test_add_overflow();
    int ds, dc; logic [3:0] r, exp_r; logic v;
`ifdef DP_ACCUM_SATURATE_EN
    exp_r = 4'hF;
`else
    exp_r = 4'h1;
`endif
    burst(1'b0, 4'd8, 4'd8, 4'd1, 4'd0, 0, 0, 0, 1'b0, ds, dc, r, v);
    n_cmp++; if (r !== exp_r) begin n_bad++; $display("FAIL addovf_d_out: got %h want %h", r, exp_r); end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL addovf_ovf: got %b want 1", v); end
  endtask

  task automatic test_handshake();
    int ds, dc; logic [3:0] r; logic v;
    burst(1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 0, 2, 1, 1'b1, ds, dc, r, v);
    n_cmp++; if (ds !== 7) begin n_bad++; $display("FAIL hs_done_edge: got %0d want 7", ds); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL hs_done_count: got %0d want 1", dc); end
    n_cmp++; if (r !== 4'h4) begin n_bad++; $display("FAIL hs_d_out: got %h want 4", r); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hs_no_second_txn: busy got %b want 0", busy); end
  endtask

  task automatic test_sub();
    int ds, dc; logic [3:0] r, exp_r; logic v;
    burst(1'b1, 4'd9, 4'd3, 4'd2, 4'd1, 0, 0, 0, 1'b0, ds, dc, r, v);
    n_cmp++; if (r !== 4'h3) begin n_bad++; $display("FAIL sub_d_out: got %h want 3", r); end
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL sub_ovf: got %b want 0", v); end
`ifdef DP_ACCUM_SATURATE_EN
    exp_r = 4'h0;
`else
    exp_r = 4'hF;
`endif
    burst(1'b1, 4'd2, 4'd3, 4'd0, 4'd0, 0, 0, 0, 1'b0, ds, dc, r, v);
    n_cmp++; if (r !== exp_r) begin n_bad++; $display("FAIL subwrap_d_out: got %h want %h", r, exp_r); end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL subwrap_ovf: got %b want 1", v); end
    n_cmp++; if (ds !== 4) begin n_bad++; $display("FAIL subwrap_done_edge: got %0d want 4", ds); end
  endtask

  task automatic test_reset_mid();
    int ds, dc; logic [3:0] r; logic v;
    op_sub = 1'b0; start = 1'b1; d_valid = 1'b0;
    step();
    start = 1'b0; d_valid = 1'b1; d_in = 4'd7;
    step();
    step();
    n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL mid_pre_d_ready: got %b want 1", d_ready); end
    d_valid = 1'b0;
    restart = 1'b1;
    #1;
    n_cmp++; if (d_out !== 4'h0) begin n_bad++; $display("FAIL mid_d_out: got %h want 0", d_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL mid_d_ready: got %b want 0", d_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    #1;
    restart = 1'b0;
    burst(1'b0, 4'd5, 4'd5, 4'd5, 4'd0, 0, 0, 0, 1'b0, ds, dc, r, v);
    n_cmp++; if (r !== 4'hF) begin n_bad++; $display("FAIL fresh_d_out: got %h want f", r); end
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL fresh_ovf: got %b want 0", v); end
    n_cmp++; if (ds !== 4) begin n_bad++; $display("FAIL fresh_done_edge: got %0d want 4", ds); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_overflow();
    test_handshake();
    test_sub();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
